// File: rtl/mcu_spi_pkg.sv
// Shared constants for the MCU SPI master: register map, register bit indices
// and the transfer state encoding.
package mcu_spi_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h1;
  localparam logic [3:0] ADDR_CS_SEL = 4'h2;
  localparam logic [3:0] ADDR_DIV    = 4'h3;
  localparam logic [3:0] ADDR_STATUS = 4'h4;

  localparam int CTRL_CPOL = 0;
  localparam int CTRL_CPHA = 1;
  localparam int CTRL_LSB  = 2;
  localparam int CTRL_HOLD = 3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_RXV   = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_tx_fifo.sv
// Transmit byte FIFO; extra pointer MSB distinguishes full from empty.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module spi_tx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full_out,
  output logic             empty_out
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_out = (r_wr_ptr == r_rd_ptr);
  assign full_out  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop_in && !empty_out;
  assign w_do_push = push_in && (!full_out || w_do_pop);
  assign data_out  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/mcu_spi_master.sv
// Register-mapped SPI master: TX FIFO, per-transfer latched mode/divider/select,
// SETUP / 16 SCLK half-periods / HOLD framing with back-to-back chaining.
import mcu_spi_pkg::*;

module mcu_spi_master #(
  parameter int NUM_CS     = 4,
  parameter int DIV_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [3:0]        periph_addr_in,
  input  logic              periph_addr_valid_in,
  input  logic              periph_write_en_in,
  input  logic [7:0]        periph_data_in,
  output logic [7:0]        periph_data_out,
  output logic              periph_data_valid_out,
  output logic              sclk_out,
  output logic              mosi_out,
  input  logic              miso_in,
  output logic [NUM_CS-1:0] cs_n_out
);

  spi_state_t r_state, w_state_nxt;

  logic                 r_valid_d;
  logic [3:0]           r_ctrl;
  logic [2:0]           r_cs_sel;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_ovf;
  logic                 r_rx_valid;
  logic [7:0]           r_rx_data;
  logic [7:0]           r_data_out;
  logic                 r_data_valid;

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [DIV_WIDTH-1:0] r_div_l;
  logic [3:0]           r_half;
  logic                 r_cpol_l, r_cpha_l, r_lsb_l, r_hold_l;
  logic [7:0]           r_tx;
  logic [7:0]           r_rx;
  logic                 r_sclk;
  logic [NUM_CS-1:0]    r_cs_n;

  logic              w_accept, w_wr, w_rd;
  logic              w_push_req, w_ovf_set;
  logic              w_fifo_full, w_fifo_empty;
  logic [7:0]        w_fifo_dout;
  logic              w_tick, w_load, w_edge, w_done;
  logic [3:0]        w_edge_half;
  logic              w_sample, w_shift;
  logic              w_busy;
  logic [7:0]        w_status;
  logic [7:0]        w_rd_data;
  logic [NUM_CS-1:0] w_cs_dec;

  // Only the first cycle of a valid-high period is an access.
  assign w_accept   = periph_addr_valid_in && !r_valid_d;
  assign w_wr       = w_accept && periph_write_en_in;
  assign w_rd       = w_accept && !periph_write_en_in;
  assign w_push_req = w_wr && (periph_addr_in == ADDR_DATA);
  assign w_ovf_set  = w_push_req && w_fifo_full && !w_load;

  spi_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .push_in   (w_push_req),
    .pop_in    (w_load),
    .data_in   (periph_data_in),
    .data_out  (w_fifo_dout),
    .full_out  (w_fifo_full),
    .empty_out (w_fifo_empty)
  );

  assign w_busy = (r_state != IDLE) || !w_fifo_empty;

  always_comb begin
    w_status           = '0;
    w_status[ST_BUSY]  = w_busy;
    w_status[ST_FULL]  = w_fifo_full;
    w_status[ST_EMPTY] = w_fifo_empty;
    w_status[ST_RXV]   = r_rx_valid;
    w_status[ST_OVF]   = r_ovf;
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (periph_addr_in)
      ADDR_DATA:   w_rd_data = r_rx_data;
      ADDR_CTRL:   w_rd_data = {4'b0, r_ctrl};
      ADDR_CS_SEL: w_rd_data = {5'b0, r_cs_sel};
      ADDR_DIV:    w_rd_data = 8'(r_div);
      ADDR_STATUS: w_rd_data = w_status;
      default:     w_rd_data = 8'h00;
    endcase
  end

  always_comb begin
    w_cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (r_cs_sel == 3'(i)) w_cs_dec[i] = 1'b0;
  end

  // Edge k is the SCLK transition that opens SHIFT half-period k.
  assign w_tick      = (r_div_cnt == r_div_l);
  assign w_edge_half = (r_state == SETUP) ? 4'd0 : r_half + 4'd1;
  assign w_sample    = r_cpha_l ? w_edge_half[0] : ~w_edge_half[0];
  assign w_shift     = r_cpha_l ? (~w_edge_half[0] && (w_edge_half != 4'd0))
                                : ( w_edge_half[0] && (w_edge_half != 4'd15));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_edge      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = SETUP;
          w_load      = 1'b1;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_state_nxt = SHIFT;
          w_edge      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (r_half == 4'd15) w_state_nxt = HOLD;
          else                 w_edge      = 1'b1;
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_done = 1'b1;
          if (!w_fifo_empty) begin
            w_state_nxt = SETUP;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_valid_d    <= 1'b0;
      r_ctrl       <= '0;
      r_cs_sel     <= '0;
      r_div        <= '0;
      r_ovf        <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_valid_d    <= periph_addr_valid_in;
      r_data_valid <= w_rd;
      if (w_rd) r_data_out <= w_rd_data;
      if (w_rd && (periph_addr_in == ADDR_DATA)) r_rx_valid <= 1'b0;
      if (w_wr) begin
        case (periph_addr_in)
          ADDR_CTRL:   r_ctrl   <= periph_data_in[3:0];
          ADDR_CS_SEL: r_cs_sel <= periph_data_in[2:0];
          ADDR_DIV:    r_div    <= periph_data_in[DIV_WIDTH-1:0];
          ADDR_STATUS: if (periph_data_in[ST_OVF]) r_ovf <= 1'b0;
          default: ;
        endcase
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      // A completed byte overwrites unread data without flagging overflow.
      if (w_done) begin
        r_rx_data  <= r_rx;
        r_rx_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_div_cnt <= '0;
      r_div_l   <= '0;
      r_half    <= '0;
      r_cpol_l  <= 1'b0;
      r_cpha_l  <= 1'b0;
      r_lsb_l   <= 1'b0;
      r_hold_l  <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= '1;
    end else begin
      if ((r_state == IDLE) || w_tick) r_div_cnt <= '0;
      else                             r_div_cnt <= r_div_cnt + 1'b1;

      if ((r_state == IDLE) && !r_ctrl[CTRL_HOLD]) r_cs_n <= '1;

      if (w_load) begin
        r_cpol_l <= r_ctrl[CTRL_CPOL];
        r_cpha_l <= r_ctrl[CTRL_CPHA];
        r_lsb_l  <= r_ctrl[CTRL_LSB];
        r_hold_l <= r_ctrl[CTRL_HOLD];
        r_div_l  <= r_div;
        r_tx     <= w_fifo_dout;
        r_sclk   <= r_ctrl[CTRL_CPOL];
        r_half   <= '0;
        r_cs_n   <= w_cs_dec;
      end

      if (w_edge) begin
        r_half <= w_edge_half;
        r_sclk <= ~r_sclk;
        if (w_sample)
          r_rx <= r_lsb_l ? {miso_in, r_rx[7:1]} : {r_rx[6:0], miso_in};
        if (w_shift)
          r_tx <= r_lsb_l ? {1'b0, r_tx[7:1]} : {r_tx[6:0], 1'b0};
      end

      if (w_done && !w_load && !r_hold_l) r_cs_n <= '1;
    end
  end

  assign sclk_out              = (r_state == IDLE) ? r_ctrl[CTRL_CPOL] : r_sclk;
  assign mosi_out              = (r_state == IDLE) ? 1'b0 : (r_lsb_l ? r_tx[0] : r_tx[7]);
  assign cs_n_out              = r_cs_n;
  assign periph_data_out       = r_data_out;
  assign periph_data_valid_out = r_data_valid;

endmodule

// File: tb/tb_mcu_spi_master.sv
// Directed bench for mcu_spi_master: framing, modes, FIFO overflow,
// chip-select hold, mid-transfer reset and access edge detection.
module tb_mcu_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] addr = '0;
  logic       av = 1'b0;
  logic       we = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       dv;
  logic       sclk, mosi, miso;
  logic [3:0] cs_n;

  int n_assert = 0;
  int n_fail   = 0;

  assign miso = mosi;

  always #5 clk = ~clk;

  mcu_spi_master #(.NUM_CS(4), .DIV_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk_in                (clk),
    .reset_in              (rst),
    .periph_addr_in        (addr),
    .periph_addr_valid_in  (av),
    .periph_write_en_in    (we),
    .periph_data_in        (din),
    .periph_data_out       (dout),
    .periph_data_valid_out (dv),
    .sclk_out              (sclk),
    .mosi_out              (mosi),
    .miso_in               (miso),
    .cs_n_out              (cs_n)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; we = 1'b1; din = d; av = 1'b1;
    @(posedge clk); #1;
    av = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(posedge clk); #1;
    addr = a; we = 1'b0; av = 1'b1;
    @(posedge clk); #1;
    av = 1'b0;
    chk({tag, "_dv"}, 8'(dv), 8'd1);
    chk(tag, dout, exp);
    @(posedge clk); #1;
    chk({tag, "_dv_off"}, 8'(dv), 8'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin : main
    int         low_cnt, rises, ntog, prev_sclk, prev_cs_low;
    int         tog_t [2];
    logic [7:0] bits;

    do_reset();
    chk("rst_cs_n", 8'(cs_n), 8'h0F);
    chk("rst_sclk", 8'(sclk), 8'd0);
    chk("rst_mosi", 8'(mosi), 8'd0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_dv",   8'(dv), 8'd0);
    rd_chk("rst_status", 4'h4, 8'h04);
    rd_chk("bad_addr", 4'h9, 8'h00);

    // Mode 0, MSB-first, fastest divider, loopback of 0xA5.
    wr(4'h1, 8'h00); wr(4'h3, 8'h00); wr(4'h2, 8'h01);
    rd_chk("cs_sel_rd", 4'h2, 8'h01);
    wr(4'h0, 8'hA5);
    low_cnt = 0; rises = 0; bits = '0; prev_sclk = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (cs_n == 4'b1101) low_cnt++;
      if (sclk && prev_sclk == 0) begin rises++; bits = {bits[6:0], mosi}; end
      prev_sclk = int'(sclk);
    end
    chk("m0_cs_len", 8'(low_cnt), 8'd18);
    chk("m0_rises", 8'(rises), 8'd8);
    chk("m0_mosi", bits, 8'hA5);
    rd_chk("m0_status_rxv", 4'h4, 8'h0C);
    rd_chk("m0_rx", 4'h0, 8'hA5);
    rd_chk("m0_status_clr", 4'h4, 8'h04);

    // CPOL=1, CPHA=1, LSB-first, DIV=3.
    wr(4'h1, 8'h07); wr(4'h3, 8'h03);
    chk("m3_idle_sclk", 8'(sclk), 8'd1);
    wr(4'h0, 8'h01);
    rises = 0; ntog = 0; bits = '0; prev_sclk = 1;
    tog_t[0] = 0; tog_t[1] = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (int'(sclk) != prev_sclk) begin
        if (ntog < 2) tog_t[ntog] = c;
        ntog++;
        if (sclk) begin
          if (rises == 0) chk("m3_first_bit", 8'(mosi), 8'd1);
          rises++; bits = {mosi, bits[7:1]};
        end
      end
      prev_sclk = int'(sclk);
    end
    chk("m3_half_period", 8'(tog_t[1] - tog_t[0]), 8'd4);
    chk("m3_toggles", 8'(ntog), 8'd16);
    chk("m3_mosi", bits, 8'h01);
    rd_chk("m3_rx", 4'h0, 8'h01);

    // Three bytes back-to-back, CS_HOLD clear.
    wr(4'h1, 8'h00); wr(4'h3, 8'h00);
    low_cnt = 0; rises = 0; prev_cs_low = 0;
    fork
      begin
        wr(4'h0, 8'h11); wr(4'h0, 8'h22); wr(4'h0, 8'h3C);
      end
      begin
        for (int c = 0; c < 90; c++) begin
          @(posedge clk); #1;
          if (cs_n == 4'b1101) low_cnt++;
          if (cs_n == 4'b1111 && prev_cs_low == 1) rises++;
          prev_cs_low = (cs_n == 4'b1101) ? 1 : 0;
        end
      end
    join
    chk("b2b_cs_len", 8'(low_cnt), 8'd54);
    chk("b2b_cs_rises", 8'(rises), 8'd1);
    rd_chk("b2b_rx", 4'h0, 8'h3C);

    // CS_HOLD keeps select low until cleared in IDLE.
    wr(4'h1, 8'h08); wr(4'h0, 8'h5A);
    repeat (40) @(posedge clk); #1;
    chk("hold_cs_low", 8'(cs_n), 8'h0D);
    rd_chk("hold_status", 4'h4, 8'h0C);
    wr(4'h1, 8'h00);
    repeat (2) @(posedge clk); #1;
    chk("hold_cs_rel", 8'(cs_n), 8'h0F);

    // Overflow while stalled in SETUP.
    do_reset();
    wr(4'h3, 8'hFF); wr(4'h0, 8'h01);
    wr(4'h0, 8'h02); wr(4'h0, 8'h03); wr(4'h0, 8'h04); wr(4'h0, 8'h05); wr(4'h0, 8'h06);
    rd_chk("ovf_status", 4'h4, 8'h13);
    wr(4'h4, 8'h10);
    rd_chk("ovf_clr", 4'h4, 8'h03);

    // Reset during SHIFT half-period 7.
    do_reset();
    chk("rst2_idle_cs", 8'(cs_n), 8'h0F);
    wr(4'h0, 8'h5A);
    repeat (9) @(posedge clk); #1;
    chk("rst2_in_shift", 8'(cs_n), 8'h0E);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_cs", 8'(cs_n), 8'h0F);
    chk("rst2_sclk", 8'(sclk), 8'd0);
    chk("rst2_mosi", 8'(mosi), 8'd0);
    rst = 1'b0;
    rd_chk("rst2_status", 4'h4, 8'h04);

    // Long valid pulse on a DATA write yields a single push.
    wr(4'h3, 8'hFF);
    @(posedge clk); #1;
    addr = 4'h0; we = 1'b1; din = 8'h77; av = 1'b1;
    repeat (5) @(posedge clk); #1;
    av = 1'b0; we = 1'b0;
    rd_chk("one_push_status", 4'h4, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_spi_master.md
MCU_SPI_MASTER -- requirements
Module: mcu_spi_master

Interface
REQ-001 Parameter NUM_CS, default 4, meaning number of chip-select channels (1..8).
REQ-002 Parameter DIV_WIDTH, default 8, meaning width of the clock-divider register (1..8).
REQ-003 Parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of 2, 2..16).
REQ-004 One clock; reset is synchronous and active-high. Ports: clk_in input 1, system clock; reset_in input 1, sync active-high reset.
REQ-005 periph_addr_in input 4, register address; periph_addr_valid_in input 1, access request; periph_write_en_in input 1, 1=write, 0=read.
REQ-006 periph_data_in input 8, write data; periph_data_out output 8, read data; periph_data_valid_out output 1, read-complete pulse.
REQ-007 sclk_out output 1, SPI clock; mosi_out output 1, SPI data out; miso_in input 1, SPI data in; cs_n_out output NUM_CS, active-low selects.

Function
REQ-008 Registers: 0x0 DATA (W: push TX FIFO; R: last RX byte, clears rx_valid); 0x1 CTRL ([0] CPOL, [1] CPHA, [2] LSB-first, [3] CS_HOLD).
REQ-009 Registers: 0x2 CS_SEL ([2:0] channel; values >= NUM_CS select none); 0x3 DIV (sclk half-period = DIV+1 clk_in cycles, DIV_WIDTH LSBs used).
REQ-010 Register 0x4 STATUS (R: [0] busy, [1] tx_full, [2] tx_empty, [3] rx_valid, [4] overflow; W: 1 to bit [4] clears overflow). Other addresses: reads return 0x00, writes ignored.
REQ-011 An access is accepted only in the first cycle of each periph_addr_valid_in high period; it is re-armed only after periph_addr_valid_in drops.
REQ-012 Write effects occur at the accepting clock edge; a read asserts periph_data_valid_out for exactly one cycle, the cycle after acceptance, with periph_data_out valid in that cycle.
REQ-013 FSM states: IDLE, SETUP, SHIFT, HOLD. IDLE -> SETUP when FIFO non-empty: pop byte, latch CTRL/CS_SEL/DIV, assert selected cs_n low.
REQ-014 SETUP lasts one half-period; SHIFT lasts 16 half-periods with sclk toggling at each boundary; HOLD lasts one half-period with sclk = CPOL.
REQ-015 CPHA=0: mosi valid from SETUP, sample miso on leading edges, shift on trailing edges; CPHA=1: shift on leading edges, sample on trailing edges. MSB-first unless LSB-first.
REQ-016 On HOLD end: RX byte stored and rx_valid set; if FIFO non-empty -> SETUP without deasserting cs (back-to-back); else -> IDLE and cs_n deasserted unless CS_HOLD=1.
REQ-017 Clearing CS_HOLD while IDLE deasserts all cs_n on the next cycle; CTRL/CS_SEL/DIV writes during a transfer take effect only at the next SETUP.
REQ-018 busy = state != IDLE or FIFO non-empty.
REQ-019 A DATA write with FIFO full is dropped and sets sticky overflow, except when a pop occurs in the same cycle, in which case the write is accepted.
REQ-020 An RX byte completing while rx_valid is already set overwrites the data; this is not an overflow.
REQ-021 In IDLE, sclk_out = CPOL from the live CTRL register.

Reset
REQ-022 Reset state: FSM IDLE; FIFO empty; all registers 0; sclk_out=0, mosi_out=0, cs_n_out all 1; periph_data_out=0x00, periph_data_valid_out=0; overflow/rx_valid 0.
REQ-023 Reset mid-transfer aborts immediately; outputs hold reset values from the cycle after the reset edge; no RX update.

Structure
REQ-024 Shared package mcu_spi_pkg holds the register address constants, STATUS/CTRL bit indices and the state enum spi_state_t.
REQ-025 One sub-module spi_tx_fifo (parameter FIFO_DEPTH, width 8) provides push/pop/full/empty; pointer wrap-around is by log2(FIFO_DEPTH)+1-bit pointers.

Verification
REQ-026 CTRL=0, DIV=0, CS_SEL=1, write DATA 0xA5, miso loopback -> cs_n_out=4'b1101 for 18 half-periods total (SETUP+16+HOLD), mosi sequence 1,0,1,0,0,1,0,1, DATA read 0xA5, rx_valid cleared.
REQ-027 CPOL=1, CPHA=1, LSB-first, DIV=3, send 0x01 -> sclk idles high, half-period 4 cycles, first mosi bit 1, miso sampled on rising edges.
REQ-028 Push 5 bytes with FIFO_DEPTH=4 while SPI stalled in SETUP -> 5th write dropped, STATUS=0x13; write 0x10 to STATUS clears bit 4.
REQ-029 Three bytes back-to-back, CS_HOLD=0 -> cs_n low continuously across all 3 bytes, high within one cycle of final HOLD; with CS_HOLD=1, cs stays low until CTRL bit 3 is cleared.
REQ-030 Assert reset_in at SHIFT half-period 7 -> next cycle cs_n all 1, sclk 0, STATUS reads 0x04; addr_valid held 5 cycles on a DATA write -> exactly one push.
